display_init_sequencer: RTL

DISPLAY_INIT_SEQUENCER -- requirements
Module: display_init_sequencer

---
 rtl/display_init_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/display_init_sequencer.sv
// -----------------------------------------------------------------------------
// display_init_sequencer
//
// Runs a display power-up script stored in an external synchronous ROM. A
// start request first pulses the display reset pin low for RESET_MS ms and then
// waits another RESET_MS ms with the pin high. After that the sequencer walks
// the ROM one entry at a time. Command and data bytes go out over a
// valid/ready byte interface. Delay entries pause for N ms. An end entry, or
// the last ROM address, finishes the script.
//
// Entry encoding (romData[9:8]):
//   00 command byte romData[7:0]   01 data byte romData[7:0]
//   10 delay of romData[7:0] ms    11 end of script
//
// Ports
//   clk            system clock, rising edge
//   resetN         asynchronous active-low reset
//   start          one-cycle run request, honoured only in IDLE or DONE
//   romAddr        script ROM address
//   romData        script entry, valid one cycle after romAddr
//   txData/txDc    byte and data(1)/command(0) flag offered downstream
//   txValid        byte offer; accepted when txValid && txReady
//   txReady        downstream accept
//   displayResetN  display hardware reset pin, active-low
//   busy           high in every state except IDLE and DONE
//   done           high only in DONE
// -----------------------------------------------------------------------------
module display_init_sequencer #(
  parameter int CLK_PER_MS = 25000,
  parameter int RESET_MS   = 10,
  parameter int ROM_DEPTH  = 64
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         start,
  output logic [$clog2(ROM_DEPTH)-1:0] romAddr,
  input  logic [9:0]                   romData,
  output logic [7:0]                   txData,
  output logic                         txDc,
  output logic                         txValid,
  input  logic                         txReady,
  output logic                         displayResetN,
  output logic                         busy,
  output logic                         done
);

  localparam int AW     = $clog2(ROM_DEPTH);
  localparam int PRE_W  = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  // The ms counter has to reach both the reset time and the longest delay.
  localparam int MS_MAX = (RESET_MS > 255) ? RESET_MS : 255;
  localparam int MS_W   = $clog2(MS_MAX);

  localparam logic [PRE_W-1:0] PRE_LAST      = PRE_W'(CLK_PER_MS - 1);
  localparam logic [MS_W-1:0]  RESET_MS_LAST = MS_W'(RESET_MS - 1);
  localparam logic [AW-1:0]    ADDR_LAST     = AW'(ROM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_WAIT, FETCH, DECODE, SEND, DELAY, DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PRE_W-1:0] pre_cnt;     // clk cycles within the current ms
  logic [MS_W-1:0]  ms_cnt;      // whole ms elapsed in the current timed state
  logic [7:0]       delay_ms;    // length of the active delay entry
  logic [MS_W-1:0]  ms_last;
  logic             timer_done;
  logic             last_entry;

  // Both counters start at 0 on entry to a timed state. The state therefore
  // lasts exactly (ms_last + 1) * CLK_PER_MS cycles.
  assign ms_last    = (state == DELAY) ? MS_W'(delay_ms - 8'd1) : RESET_MS_LAST;
  assign timer_done = (pre_cnt == PRE_LAST) && (ms_cnt == ms_last);
  // The last ROM entry never advances the address, so it cannot wrap to 0.
  assign last_entry = (romAddr == ADDR_LAST);

  // Outputs are decoded straight from the state register. Reset therefore
  // forces them to their idle values without needing a clock edge.
  assign txValid       = (state == SEND);
  assign displayResetN = (state != RST_LOW);
  assign busy          = (state != IDLE) && (state != DONE);
  assign done          = (state == DONE);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)      state_nxt = RST_LOW;
      RST_LOW:    if (timer_done) state_nxt = RST_WAIT;
      RST_WAIT:   if (timer_done) state_nxt = FETCH;
      FETCH:                      state_nxt = DECODE;
      DECODE: begin
        case (romData[9:8])
          2'b00, 2'b01: state_nxt = SEND;
          2'b10: begin
            if (romData[7:0] != 8'd0) state_nxt = DELAY;
            else                      state_nxt = last_entry ? DONE : FETCH;
          end
          default:      state_nxt = DONE;
        endcase
      end
      SEND:  if (txReady)    state_nxt = last_entry ? DONE : FETCH;
      DELAY: if (timer_done) state_nxt = last_entry ? DONE : FETCH;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      romAddr  <= '0;
      txData   <= '0;
      txDc     <= 1'b0;
      delay_ms <= '0;
      pre_cnt  <= '0;
      ms_cnt   <= '0;
    end else begin
      // Any state change restarts the ms timer. Only timed states count.
      if (state_nxt != state) begin
        pre_cnt <= '0;
        ms_cnt  <= '0;
      end else if (state inside {RST_LOW, RST_WAIT, DELAY}) begin
        if (pre_cnt == PRE_LAST) begin
          pre_cnt <= '0;
          ms_cnt  <= ms_cnt + MS_W'(1);
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end

      case (state)
        IDLE, DONE: if (start) romAddr <= '0;
        DECODE: begin
          if (!romData[9]) begin
            // Byte entry: the offer is registered here and held through SEND.
            txData <= romData[7:0];
            txDc   <= romData[8];
          end else if (!romData[8]) begin
            delay_ms <= romData[7:0];
            // A zero-length delay skips DELAY and moves to the next entry.
            if ((romData[7:0] == 8'd0) && !last_entry) romAddr <= romAddr + AW'(1);
          end
        end
        SEND:  if (txReady && !last_entry)    romAddr <= romAddr + AW'(1);
        DELAY: if (timer_done && !last_entry) romAddr <= romAddr + AW'(1);
        default: ;
      endcase
    end
  end

endmodule
